// File: rtl/vault_code_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vault_code_entry                                                         |
// | Keypad front end: collects a digit code, compares it against the stored  |
// | password, emits ENTER/MATCH and enforces a lockout after repeated misses.|
// | Optional: CODE_PROGRAM_EN adds PROG to reprogram the stored code.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vault_code_entry #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         RESETN,
  input  logic                         KEY_VALID,
  input  logic [DIGIT_W-1:0]           KEY_DIGIT,
  input  logic                         KEY_ENTER,
  input  logic                         KEY_CLEAR,
`ifdef CODE_PROGRAM_EN
  input  logic                         PROG,
`endif
  output logic                         ENTER,
  output logic                         MATCH,
  output logic [$clog2(DIGITS+1)-1:0]  DIGIT_COUNT,
  output logic                         LOCKOUT
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int LCK_W  = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_REPORT  = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_valid_cur, r_valid_prev;
  logic                r_enter_cur, r_enter_prev;
  logic                r_clear_cur, r_clear_prev;
  logic [DIGIT_W-1:0]  r_digit;
  logic [CODE_W-1:0]   r_buf;
  logic [CODE_W-1:0]   r_code;
  logic [CNT_W-1:0]    r_count;
  logic [FAIL_W-1:0]   r_fails;
  logic [LCK_W-1:0]    r_lock_cnt;
  logic                r_enter;
  logic                r_match;
  logic                r_lockout;

  logic                w_digit_ev;
  logic                w_enter_ev;
  logic                w_clear_ev;
  logic                w_full;
  logic                w_prog_ok;
  logic [FAIL_W-1:0]   w_fails_inc;

  assign w_digit_ev  = r_valid_cur & ~r_valid_prev;
  assign w_enter_ev  = r_enter_cur & ~r_enter_prev;
  assign w_clear_ev  = r_clear_cur & ~r_clear_prev;
  assign w_full      = (r_count == CNT_W'(DIGITS));
  assign w_fails_inc = (r_fails == FAIL_W'(MAX_TRIES)) ? r_fails : r_fails + 1'b1;

`ifdef CODE_PROGRAM_EN
  logic r_prog;
  // Reprogramming is only allowed right after a successful attempt with a full buffer.
  assign w_prog_ok = r_prog & w_full & r_match;
`else
  assign w_prog_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!RESETN) begin
      r_state      <= S_IDLE;
      r_valid_cur  <= 1'b0;
      r_valid_prev <= 1'b0;
      r_enter_cur  <= 1'b0;
      r_enter_prev <= 1'b0;
      r_clear_cur  <= 1'b0;
      r_clear_prev <= 1'b0;
      r_digit      <= '0;
      r_buf        <= '0;
      r_code       <= DEFAULT_CODE;
      r_count      <= '0;
      r_fails      <= '0;
      r_lock_cnt   <= '0;
      r_enter      <= 1'b0;
      r_match      <= 1'b0;
      r_lockout    <= 1'b0;
    end else begin
      r_valid_cur  <= KEY_VALID;
      r_valid_prev <= r_valid_cur;
      r_enter_cur  <= KEY_ENTER;
      r_enter_prev <= r_enter_cur;
      r_clear_cur  <= KEY_CLEAR;
      r_clear_prev <= r_clear_cur;
      r_digit      <= KEY_DIGIT;
      r_enter      <= 1'b0;

      case (r_state)
        S_IDLE, S_COLLECT: begin
          if (w_clear_ev) begin
            r_buf   <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
          end else if (w_enter_ev) begin
            if (w_prog_ok) begin
              r_code  <= r_buf;
              r_buf   <= '0;
              r_count <= '0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_CHECK;
            end
          end else if (w_digit_ev && !w_full) begin
            r_buf   <= (r_buf << DIGIT_W) | CODE_W'(r_digit);
            r_count <= r_count + 1'b1;
            r_state <= S_COLLECT;
          end
        end

        S_CHECK: begin
          r_enter <= 1'b1;
          r_match <= w_full && (r_buf == r_code);
          r_buf   <= '0;
          r_count <= '0;
          r_state <= S_REPORT;
        end

        S_REPORT: begin
          if (r_match) begin
            r_fails <= '0;
            r_state <= S_IDLE;
          end else if (w_fails_inc == FAIL_W'(MAX_TRIES)) begin
            r_fails    <= w_fails_inc;
            r_lock_cnt <= '0;
            r_lockout  <= 1'b1;
            r_state    <= S_LOCKOUT;
          end else begin
            r_fails <= w_fails_inc;
            r_state <= S_IDLE;
          end
        end

        S_LOCKOUT: begin
          if (r_lock_cnt == LCK_W'(LOCKOUT_CYCLES - 1)) begin
            r_fails   <= '0;
            r_lockout <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase

`ifdef CODE_PROGRAM_EN
      r_prog <= PROG;
`endif
    end
  end

`ifdef CODE_PROGRAM_EN
  initial begin end
`endif

  assign ENTER       = r_enter;
  assign MATCH       = r_match;
  assign DIGIT_COUNT = r_count;
  assign LOCKOUT     = r_lockout;

endmodule
`default_nettype wire

// File: tb/tb_vault_code_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vault_code_entry                                                      |
// | Randomized bench for vault_code_entry against a transaction-level model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vault_code_entry;
  localparam int DIGITS         = 4;
  localparam int DIGIT_W        = 4;
  localparam int MAX_TRIES      = 3;
  localparam int LOCKOUT_CYCLES = 1000;
  localparam logic [15:0] DEFAULT_CODE = 16'h1234;

  logic       clk = 1'b0;
  logic       RESETN = 1'b0;
  logic       KEY_VALID = 1'b0;
  logic [3:0] KEY_DIGIT = 4'h0;
  logic       KEY_ENTER = 1'b0;
  logic       KEY_CLEAR = 1'b0;
  logic       PROG = 1'b0;
  logic       ENTER, MATCH, LOCKOUT;
  logic [2:0] DIGIT_COUNT;

  always #5 clk = ~clk;

  vault_code_entry #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .DEFAULT_CODE(DEFAULT_CODE),
    .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .RESETN(RESETN),
    .KEY_VALID(KEY_VALID), .KEY_DIGIT(KEY_DIGIT),
    .KEY_ENTER(KEY_ENTER), .KEY_CLEAR(KEY_CLEAR),
`ifdef CODE_PROGRAM_EN
    .PROG(PROG),
`endif
    .ENTER(ENTER), .MATCH(MATCH), .DIGIT_COUNT(DIGIT_COUNT), .LOCKOUT(LOCKOUT)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: the entered digits as a list, plus attempt bookkeeping in cycle numbers.
  logic [3:0]  m_q[$];
  logic [15:0] m_code;
  int          m_fails;
  logic        m_match;
  logic        pend_hit;
  int          enter_at;
  int          lock_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_lock(input int c);
    return (c >= lock_start) && (c < lock_start + LOCKOUT_CYCLES);
  endfunction

  function automatic logic [15:0] m_value();
    logic [15:0] v = 16'h0;
    foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_code     = DEFAULT_CODE;
    m_fails    = 0;
    m_match    = 1'b0;
    pend_hit   = 1'b0;
    enter_at   = -1;
    lock_start = -100000;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc == enter_at) m_match = pend_hit;
    check("enter", 32'(ENTER), 32'(cyc == enter_at));
    check("match", 32'(MATCH), 32'(m_match));
    check("lockout", 32'(LOCKOUT), 32'(in_lock(cyc)));
  endtask

  task automatic press_digit(input logic [3:0] d, input int hold);
    int c0 = cyc;
    KEY_DIGIT = d;
    KEY_VALID = 1'b1;
    if (!in_lock(c0 + 1) && m_q.size() < DIGITS) m_q.push_back(d);
    repeat (hold) tick();
    KEY_VALID = 1'b0;
    repeat (2) tick();
    check("count_digit", 32'(DIGIT_COUNT), 32'(m_q.size()));
  endtask

  task automatic enter_code(input logic [15:0] v);
    for (int i = 0; i < DIGITS; i++) press_digit(v[15-4*i -: 4], 1);
  endtask

  task automatic do_enter(input bit prog);
    int c0 = cyc;
    KEY_ENTER = 1'b1;
    PROG = prog;
    if (!in_lock(c0 + 1)) begin
      if (prog && m_q.size() == DIGITS && m_match) begin
        m_code = m_value();
        m_q.delete();
      end else begin
        pend_hit = (m_q.size() == DIGITS) && (m_value() == m_code);
        enter_at = c0 + 3;
        m_q.delete();
        if (pend_hit) m_fails = 0;
        else begin
          m_fails++;
          if (m_fails >= MAX_TRIES) begin
            lock_start = c0 + 4;
            m_fails = 0;
          end
        end
      end
    end
    tick();
    KEY_ENTER = 1'b0;
    PROG = 1'b0;
    repeat (4) tick();
    check("count_enter", 32'(DIGIT_COUNT), 32'(m_q.size()));
  endtask

  task automatic do_clear(input bit with_enter);
    int c0 = cyc;
    KEY_CLEAR = 1'b1;
    KEY_ENTER = with_enter;
    if (!in_lock(c0 + 1)) m_q.delete();
    tick();
    KEY_CLEAR = 1'b0;
    KEY_ENTER = 1'b0;
    repeat (3) tick();
    check("count_clear", 32'(DIGIT_COUNT), 32'(m_q.size()));
  endtask

  task automatic wait_unlock();
    while (in_lock(cyc + 1)) tick();
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    model_reset();
    tick();
    check("count_reset", 32'(DIGIT_COUNT), 32'd0);
    RESETN = 1'b1;
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation exceeded time budget (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    tick();
    do_reset();

    enter_code(16'h1234); do_enter(1'b0);
    enter_code(16'h1235); do_enter(1'b0);
    enter_code(16'h1234); do_enter(1'b0);

    enter_code(16'h1111); do_enter(1'b0);
    enter_code(16'h2222); do_enter(1'b0);
    enter_code(16'h3333); do_enter(1'b0);
    enter_code(16'h1234); do_enter(1'b0);
    wait_unlock();
    enter_code(16'h1234); do_enter(1'b0);

    press_digit(4'h1, 1); press_digit(4'h2, 1); do_enter(1'b0);
    enter_code(16'h1234); press_digit(4'h9, 2); do_enter(1'b0);

    press_digit(4'h1, 1); press_digit(4'h2, 1); press_digit(4'h3, 1);
    do_clear(1'b1);
    press_digit(4'h7, 50);
    do_clear(1'b0);

    enter_code(16'h0000); do_enter(1'b0);
    enter_code(16'h0001); do_enter(1'b0);
    enter_code(16'h0002); do_enter(1'b0);
    repeat (20) tick();
    do_reset();
    enter_code(16'h1234); do_enter(1'b0);

`ifdef CODE_PROGRAM_EN
    enter_code(16'h1234); do_enter(1'b0);
    enter_code(16'h5678); do_enter(1'b1);
    enter_code(16'h5678); do_enter(1'b0);
    enter_code(16'h1234); do_enter(1'b0);
    enter_code(16'h5678); do_enter(1'b0);
`endif

    for (int it = 0; it < 150; it++) begin
      int op;
      if (in_lock(cyc + 1) && $urandom_range(0, 3) != 0) wait_unlock();
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        logic [3:0] d;
        if (m_q.size() < DIGITS && $urandom_range(0, 1) == 1)
          d = 4'(m_code >> (4 * (DIGITS - 1 - m_q.size())));
        else
          d = 4'($urandom_range(0, 15));
        press_digit(d, $urandom_range(1, 4));
      end else if (op <= 6) begin
`ifdef CODE_PROGRAM_EN
        do_enter($urandom_range(0, 3) == 0);
`else
        do_enter(1'b0);
`endif
      end else if (op == 7) begin
        do_clear(1'b0);
      end else if (op == 8) begin
        do_clear(1'b1);
      end else begin
        enter_code(m_code);
        do_enter(1'b0);
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
